alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 19 +
 rtl/issue_regfile.sv | 37 +++
 rtl/alu_issue.sv | 153 +++++++++++++++
 tb/tb_alu_issue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue block: parameter defaults, alu
// opcode constants and the issue FSM state encoding.
// Optional feature macro: ALU_ISSUE_IMM_EN (16-bit sign-extended immediate).
package alu_issue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AW_DEF     = 5;

  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/issue_regfile.sv
// Register file for alu_issue: two async read ports, one sync write port,
// register 0 reads as zero and ignores writes, async active-low clear.
module issue_regfile #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_a,
  input  logic [AW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 1 << AW;

  logic [DATA_W-1:0] mem [NREG];

  // Storage: cleared on reset, writes to index 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Async reads with register 0 hardwired to zero.
  always_comb begin
    rd_a = (ra_a == '0) ? '0 : mem[ra_a];
    rd_b = (ra_b == '0) ? '0 : mem[ra_b];
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: serialising single-op issue FSM (IDLE->READ->EXEC->WB) in front
// of an external combinational alu, with a direct register-load port.
// Optional feature macro: ALU_ISSUE_IMM_EN adds In_use_imm/In_imm, which
// replace operand B with a sign-extended 16-bit immediate.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [3:0]        In_op,
  input  logic [AW-1:0]     In_rs,
  input  logic [AW-1:0]     In_rt,
  input  logic [AW-1:0]     In_rd,
`ifdef ALU_ISSUE_IMM_EN
  input  logic              In_use_imm,
  input  logic [15:0]       In_imm,
`endif
  input  logic              Ld_valid,
  input  logic [AW-1:0]     Ld_rd,
  input  logic [DATA_W-1:0] Ld_data,
  output logic [DATA_W-1:0] Alu_A,
  output logic [DATA_W-1:0] Alu_B,
  output logic [3:0]        Alu_Op,
  input  logic [DATA_W-1:0] Alu_Out,
  input  logic              Alu_Zero,
  output logic              Wb_valid,
  output logic [AW-1:0]     Wb_rd,
  output logic [DATA_W-1:0] Wb_data,
  output logic              Zero_flag
);

  state_t state, state_nxt;

  logic [3:0]        op_q;
  logic [AW-1:0]     rs_q, rt_q, rd_q;
  logic              accept, ld_go;
  logic [DATA_W-1:0] rf_a, rf_b, opb_src;
  logic              rf_we;
  logic [AW-1:0]     rf_wa;
  logic [DATA_W-1:0] rf_wd;

  assign In_ready = (state == IDLE) && !Ld_valid;
  assign accept   = In_valid && In_ready;
  assign ld_go    = (state == IDLE) && Ld_valid;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: every non-IDLE state lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request fields at the accept handshake.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= In_op;
      rs_q <= In_rs;
      rt_q <= In_rt;
      rd_q <= In_rd;
    end
  end

`ifdef ALU_ISSUE_IMM_EN
  logic        use_imm_q;
  logic [15:0] imm_q;

  // Immediate fields travel with the rest of the request.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      use_imm_q <= 1'b0;
      imm_q     <= '0;
    end else if (accept) begin
      use_imm_q <= In_use_imm;
      imm_q     <= In_imm;
    end
  end

  assign opb_src = use_imm_q ? {{(DATA_W-16){imm_q[15]}}, imm_q} : rf_b;
`else
  assign opb_src = rf_b;
`endif

  // Operand latches double as the alu drive; they hold outside EXEC.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Alu_A  <= '0;
      Alu_B  <= '0;
      Alu_Op <= '0;
    end else if (state == READ) begin
      Alu_A  <= rf_a;
      Alu_B  <= opb_src;
      Alu_Op <= op_q;
    end
  end

  // Result capture at the end of EXEC; Wb_valid is high only during WB.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Wb_valid  <= 1'b0;
      Wb_rd     <= '0;
      Wb_data   <= '0;
      Zero_flag <= 1'b0;
    end else begin
      Wb_valid <= (state == EXEC);
      if (state == EXEC) begin
        Wb_rd     <= rd_q;
        Wb_data   <= Alu_Out;
        Zero_flag <= Alu_Zero;
      end
    end
  end

  // Loads and writeback are mutually exclusive by state, so a simple mux.
  always_comb begin
    rf_we = ld_go || (state == WB);
    rf_wa = ld_go ? Ld_rd   : Wb_rd;
    rf_wd = ld_go ? Ld_data : Wb_data;
  end

  issue_regfile #(.DATA_W(DATA_W), .AW(AW)) u_regfile (
    .clk   (Clk),
    .rst_n (Rst_n),
    .ra_a  (rs_q),
    .ra_b  (rt_q),
    .rd_a  (rf_a),
    .rd_b  (rf_b),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a driver issues ops/loads and pushes the
// expected writeback; a monitor pops and compares on every Wb_valid.
module tb_alu_issue;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          In_valid;
  logic          In_ready;
  logic [3:0]    In_op;
  logic [AW-1:0] In_rs, In_rt, In_rd;
  logic          In_use_imm;
  logic [15:0]   In_imm;
  logic          Ld_valid;
  logic [AW-1:0] Ld_rd;
  logic [DW-1:0] Ld_data;
  logic [DW-1:0] Alu_A, Alu_B, Alu_Out;
  logic [3:0]    Alu_Op;
  logic          Alu_Zero;
  logic          Wb_valid;
  logic [AW-1:0] Wb_rd;
  logic [DW-1:0] Wb_data;
  logic          Zero_flag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          zero;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mregs [32];
  logic          mz;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] alu_f(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return a ^ b;
    endcase
  endfunction

  // Combinational alu model in front of the DUT.
  assign Alu_Out  = alu_f(Alu_Op, Alu_A, Alu_B);
  assign Alu_Zero = (Alu_Out == '0);

  alu_issue #(.DATA_W(DW), .AW(AW)) dut (
    .Clk       (Clk),
`ifdef ALU_ISSUE_IMM_EN
    .In_use_imm(In_use_imm),
    .In_imm    (In_imm),
`endif
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_op     (In_op),
    .In_rs     (In_rs),
    .In_rt     (In_rt),
    .In_rd     (In_rd),
    .Ld_valid  (Ld_valid),
    .Ld_rd     (Ld_rd),
    .Ld_data   (Ld_data),
    .Alu_A     (Alu_A),
    .Alu_B     (Alu_B),
    .Alu_Op    (Alu_Op),
    .Alu_Out   (Alu_Out),
    .Alu_Zero  (Alu_Zero),
    .Wb_valid  (Wb_valid),
    .Wb_rd     (Wb_rd),
    .Wb_data   (Wb_data),
    .Zero_flag (Zero_flag)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: an op reads the architectural registers as of its accept.
  function automatic void push_exp(logic [3:0] op, logic [AW-1:0] rs, logic [AW-1:0] rt,
                                   logic [AW-1:0] rd, logic ui, logic [15:0] imm);
    exp_t e;
    logic [DW-1:0] a, b;
    a = (rs == 0) ? '0 : mregs[rs];
    b = (rt == 0) ? '0 : mregs[rt];
`ifdef ALU_ISSUE_IMM_EN
    if (ui) b = DW'($signed(imm));
`else
    if (ui && imm != 0) b = b;
`endif
    e.rd   = rd;
    e.data = alu_f(op, a, b);
    e.zero = (e.data == 0);
    e.acc  = cyc;
    sb.push_back(e);
    if (rd != 0) mregs[rd] = e.data;
    mz = e.zero;
  endfunction

  // Monitor: every writeback must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Rst_n && Wb_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", Wb_data, e.data);
        chk("wb_rd", Wb_rd, e.rd);
        chk("zero_flag", Zero_flag, e.zero);
        chk("latency", cyc - e.acc, 3);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("wb_timeout", 1, 0);
      sb.delete();
    end
    @(negedge Clk);
  endtask

  task automatic issue(logic [3:0] op, logic [AW-1:0] rs, logic [AW-1:0] rt,
                       logic [AW-1:0] rd, logic ui, logic [15:0] imm, bit wait_it);
    int n = 0;
    @(negedge Clk);
    In_valid = 1; In_op = op; In_rs = rs; In_rt = rt; In_rd = rd;
    In_use_imm = ui; In_imm = imm;
    #1;
    while (!In_ready && n < 20) begin
      @(negedge Clk); #1; n++;
    end
    if (!In_ready) begin
      chk("accept_timeout", 1, 0);
    end else begin
      push_exp(op, rs, rt, rd, ui, imm);
    end
    @(negedge Clk);
    In_valid = 0;
    if (wait_it) wait_done();
  endtask

  task automatic load(logic [AW-1:0] rd, logic [DW-1:0] d);
    @(negedge Clk);
    Ld_valid = 1; Ld_rd = rd; Ld_data = d;
    if (rd != 0) mregs[rd] = d;
    @(negedge Clk);
    Ld_valid = 0;
    #1;
    chk("zero_hold_on_ld", Zero_flag, mz);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mz = 0;
  endtask

  initial begin
    Rst_n = 0; In_valid = 0; In_op = 0; In_rs = 0; In_rt = 0; In_rd = 0;
    In_use_imm = 0; In_imm = 0; Ld_valid = 0; Ld_rd = 0; Ld_data = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_wb_valid", Wb_valid, 0);
    chk("rst_wb_data", Wb_data, 0);
    chk("rst_alu_a", Alu_A, 0);
    chk("rst_zero", Zero_flag, 0);
    @(negedge Clk);
    Rst_n = 1;
    #1;
    chk("ready_after_rst", In_ready, 1);

    // Basic add.
    load(1, 15); load(2, 10);
    issue(4'h2, 1, 2, 3, 0, 0, 1);

    // Subtract to zero, then add using the written-back result.
    load(1, 11); load(2, 11);
    issue(4'h6, 1, 2, 4, 0, 0, 1);
    issue(4'h2, 4, 1, 5, 0, 0, 1);

    // Load and request together: load wins, op accepted one cycle later.
    @(negedge Clk);
    Ld_valid = 1; Ld_rd = 6; Ld_data = 32'd100;
    In_valid = 1; In_op = 4'h2; In_rs = 6; In_rt = 1; In_rd = 7; In_use_imm = 0;
    #1;
    chk("ready_low_with_ld", In_ready, 0);
    mregs[6] = 32'd100;
    @(negedge Clk);
    Ld_valid = 0;
    #1;
    chk("ready_after_ld", In_ready, 1);
    push_exp(4'h2, 6, 1, 7, 0, 0);
    @(negedge Clk);
    In_valid = 0;
    wait_done();

    // Writeback to r0 pulses but is dropped; r0 reads as zero.
    load(1, 15); load(2, 10);
    issue(4'h2, 1, 2, 0, 0, 0, 1);
    issue(4'h2, 0, 0, 8, 0, 0, 1);
    issue(4'h2, 0, 1, 9, 0, 0, 1);
    load(0, 32'hDEAD);
    issue(4'h1, 0, 0, 10, 0, 0, 1);

    // Reset during EXEC: op discarded, registers cleared.
    load(11, 32'h55);
    issue(4'h2, 11, 11, 12, 0, 0, 0);
    @(negedge Clk);
    Rst_n = 0;
    sb.delete();
    model_reset();
    #1;
    chk("mid_rst_wb_valid", Wb_valid, 0);
    chk("mid_rst_alu_op", Alu_Op, 0);
    chk("mid_rst_alu_b", Alu_B, 0);
    chk("mid_rst_wb_rd", Wb_rd, 0);
    @(negedge Clk);
    Rst_n = 1;
    #1;
    chk("ready_after_mid_rst", In_ready, 1);
    repeat (3) @(negedge Clk);
    issue(4'h1, 11, 12, 13, 0, 0, 1);
    issue(4'h2, 1, 2, 14, 0, 0, 1);

`ifdef ALU_ISSUE_IMM_EN
    load(1, 20);
    issue(4'h2, 1, 0, 3, 1, 16'hFFF5, 1);
`endif

    // Randomized mix of loads and ops.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ops [5];
      ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h6; ops[4] = 4'h7;
      if ($urandom_range(0, 2) == 0)
        load(AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      issue(ops[$urandom_range(0, 4)], AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
